game_controller: RTL

- Control unit (FSM) for the reaction/memory game.
- Its command outputs drive the datapath's command inputs: r1, r2, e1–e4, sel.
- It sequences the game from the datapath status outputs: end_fpga, end_user, end_time, win, match.
- It also conditions the raw "enter" push-button into a single-cycle press event. The top level instantiates it next to the datapath on clock_50.

---
 rtl/game_controller.sv | 123 ++++++++++++
 1 files changed

// File: rtl/game_controller.sv
// Control FSM for the reaction/memory game: conditions the enter key into a
// one-cycle press and sequences the datapath through setup, playback, entry and result.
module game_controller #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock_50,
    input  logic       R,
    input  logic       enter_n,
    input  logic       end_fpga,
    input  logic       end_user,
    input  logic       end_time,
    input  logic       win,
    input  logic       match,
    output logic       r1,
    output logic       r2,
    output logic       e1,
    output logic       e2,
    output logic       e3,
    output logic       e4,
    output logic       sel,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        INIT       = 3'd0,
        SETUP      = 3'd1,
        PLAY_FPGA  = 3'd2,
        PLAY_USER  = 3'd3,
        CHECK      = 3'd4,
        NEXT_ROUND = 3'd5,
        RESULT     = 3'd6
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev_q;
    logic                   press_q;
    logic [2:0]             state_q;
    state_t                 cur_state;
    state_t                 next_state;

    // Registered falling-edge detect keeps press one cycle wide however long the key is held
    always_ff @(posedge clock_50 or posedge R) begin
        if (R) begin
            sync_q      <= '1;
            sync_prev_q <= 1'b1;
            press_q     <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], enter_n};
            sync_prev_q <= sync_q[SYNC_STAGES-1];
            press_q     <= sync_prev_q & ~sync_q[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clock_50 or posedge R) begin
        if (R) begin
            state_q <= INIT;
        end else begin
            state_q <= next_state;
        end
    end

    // Raw register is cast so the unused code 7 falls into the default recovery arm
    assign cur_state = state_t'(state_q);
    assign state     = state_q;

    always_comb begin
        next_state = INIT;
        r1  = 1'b0;
        r2  = 1'b0;
        e1  = 1'b0;
        e2  = 1'b0;
        e3  = 1'b0;
        e4  = 1'b0;
        sel = 1'b0;
        case (cur_state)
            INIT: begin
                r1         = 1'b1;
                r2         = 1'b1;
                next_state = SETUP;
            end
            SETUP: begin
                e1         = 1'b1;
                next_state = press_q ? PLAY_FPGA : SETUP;
            end
            PLAY_FPGA: begin
                e3         = 1'b1;
                r2         = 1'b1;
                next_state = end_fpga ? PLAY_USER : PLAY_FPGA;
            end
            PLAY_USER: begin
                e2 = 1'b1;
                e4 = 1'b1;
                if (end_time) begin
                    next_state = RESULT;
                end else if (end_user) begin
                    next_state = CHECK;
                end else begin
                    next_state = PLAY_USER;
                end
            end
            CHECK: begin
                // A mismatch ends the game even on the final round
                if (!match || win) begin
                    next_state = RESULT;
                end else begin
                    next_state = NEXT_ROUND;
                end
            end
            NEXT_ROUND: begin
                r2         = 1'b1;
                next_state = PLAY_FPGA;
            end
            RESULT: begin
                sel        = 1'b1;
                next_state = press_q ? INIT : RESULT;
            end
            default: begin
                next_state = INIT;
            end
        endcase
    end

endmodule
